decimator_stream: RTL and testbench

//   Streaming 2:1 decimating low-pass filter; the down-sampling counterpart of the

---
 rtl/decim_pkg.sv | 36 +++
 rtl/decim_tap_sum.sv | 16 +
 rtl/decimator_stream.sv | 100 ++++++++++
 tb/tb_decimator_stream.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decim_pkg.sv
// Shared widths, filter coefficients and sample/accumulator types for the 2:1 decimator.
// tap_mul expands each constant coefficient into shifts and adds.
package decim_pkg;

   localparam int DATA_W  = 8;
   localparam int ACC_W   = 17;
   localparam int FRAC_SH = 6;

   // Symmetric low-pass kernel, newest sample first; coefficients sum to 64
   localparam int C0 = -1;
   localparam int C1 = -2;
   localparam int C2 = 9;
   localparam int C3 = 26;
   localparam int C4 = 26;
   localparam int C5 = 9;
   localparam int C6 = -2;
   localparam int C7 = -1;

   typedef logic [DATA_W-1:0]       sample_t;
   typedef logic signed [ACC_W-1:0] acc_t;

   localparam sample_t MAX_OUT = sample_t'((1 << DATA_W) - 1);

   function automatic acc_t tap_mul(input sample_t s, input int c);
      acc_t x;
      x = acc_t'({{(ACC_W-DATA_W){1'b0}}, s});
      case (c)
         26:      tap_mul = (x <<< 4) + (x <<< 3) + (x <<< 1);
         9:       tap_mul = (x <<< 3) + x;
         -1:      tap_mul = -x;
         -2:      tap_mul = -(x <<< 1);
         default: tap_mul = '0;
      endcase
   endfunction

endpackage

// File: rtl/decim_tap_sum.sv
// Combinational 8-tap signed sum over the window; x_i[0] is the newest sample.
module decim_tap_sum
   import decim_pkg::*;
(
   input  sample_t [7:0] x_i,
   output acc_t          sum_o
);

   always_comb begin
      sum_o = tap_mul(x_i[0], C0) + tap_mul(x_i[1], C1)
            + tap_mul(x_i[2], C2) + tap_mul(x_i[3], C3)
            + tap_mul(x_i[4], C4) + tap_mul(x_i[5], C5)
            + tap_mul(x_i[6], C6) + tap_mul(x_i[7], C7);
   end

endmodule

// File: rtl/decimator_stream.sv
// Streaming 2:1 decimating low-pass filter: 8-sample window, one rounded and clamped
// result per two accepted samples, held in a registered valid/ready output stage.
module decimator_stream
   import decim_pkg::*;
(
   input  logic              clock,
   input  logic              reset_L,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   sample_t [7:0] win_q, win_d;
   logic [3:0]    fill_q, fill_d;
   logic          phase_q, phase_d;
   logic          out_valid_q, out_valid_d;
   sample_t       out_data_q, out_data_d;

   logic          accept;
   logic          emit;
   sample_t [7:0] taps;
   acc_t          sum;
   acc_t          rnd;
   sample_t       res;

   assign in_ready = ~out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;
   // Odd-numbered accepts from the eighth onward see a window of eight real samples
   assign emit     = accept & phase_q & (fill_q >= 4'd7);

   assign taps = {win_q[6:0], sample_t'(in_data)};

   decim_tap_sum u_tap_sum (
      .x_i   (taps),
      .sum_o (sum)
   );

   assign rnd = (sum + acc_t'(1 << (FRAC_SH - 1))) >>> FRAC_SH;

   always_comb begin
      res = rnd[DATA_W-1:0];
      if (rnd < 0) begin
         res = '0;
      end else if (rnd > acc_t'(MAX_OUT)) begin
         res = MAX_OUT;
      end
   end

   always_comb begin
      win_d       = win_q;
      fill_d      = fill_q;
      phase_d     = phase_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (flush) begin
         win_d       = '0;
         fill_d      = '0;
         phase_d     = 1'b0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
      end else begin
         if (accept) begin
            win_d   = {win_q[6:0], sample_t'(in_data)};
            fill_d  = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
            phase_d = ~phase_q;
         end
         // A fresh result takes priority over retiring the one being delivered
         if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = res;
         end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         win_q       <= '0;
         fill_q      <= '0;
         phase_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         win_q       <= win_d;
         fill_q      <= fill_d;
         phase_q     <= phase_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_decimator_stream.sv
// Directed bench for decimator_stream: hand-computed vectors plus a reference
// scoreboard that checks every delivered result in order.
module tb_decimator_stream;

   logic       clock = 1'b0;
   logic       reset_L = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;

   int n_checks = 0;
   int n_errors = 0;
   int n_xfer = 0;

   int mwin[8];
   int mfill;
   int mphase;
   int exp_q[$];

   decimator_stream dut (
      .clock     (clock),
      .reset_L   (reset_L),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) mwin[i] = 0;
      mfill  = 0;
      mphase = 0;
      exp_q.delete();
   endtask

   task automatic model_accept(input int d);
      int s;
      if (mphase == 1 && mfill >= 7) begin
         s = -d - 2*mwin[0] + 9*mwin[1] + 26*mwin[2] + 26*mwin[3]
             + 9*mwin[4] - 2*mwin[5] - mwin[6];
         s = (s + 32) >>> 6;
         if (s < 0) s = 0;
         if (s > 255) s = 255;
         exp_q.push_back(s);
      end
      for (int i = 7; i > 0; i--) mwin[i] = mwin[i-1];
      mwin[0] = d;
      if (mfill < 8) mfill++;
      mphase = 1 - mphase;
   endtask

   always @(negedge clock) begin
      if (!reset_L || flush) begin
         model_clear();
      end else begin
         if (out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) check_val("unexpected_out", 1, 0);
            else check_val("stream_out", int'(out_data), exp_q.pop_front());
         end
         if (in_valid && in_ready) model_accept(int'(in_data));
      end
   end

   task automatic send(input int d);
      logic acc;
      int   waited;
      in_data  = 8'(d);
      in_valid = 1'b1;
      waited   = 0;
      do begin
         @(negedge clock);
         acc = in_ready;
         @(posedge clock);
         #1;
         waited++;
      end while (!acc && waited < 200);
      in_valid = 1'b0;
      if (!acc) check_val("send_timeout", 0, 1);
   endtask

   task automatic send_n(input int n, input int d);
      for (int i = 0; i < n; i++) send(d);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
   endtask

   int vec[6][8] = '{
      '{0, 255, 255, 0, 0, 255, 255, 0},
      '{0, 255, 0, 0, 0, 0, 255, 0},
      '{0, 0, 255, 255, 255, 255, 0, 0},
      '{10, 20, 30, 40, 50, 60, 70, 80},
      '{0, 0, 0, 0, 1, 1, 1, 1},
      '{1, 0, 0, 0, 1, 1, 1, 1}
   };
   int vexp[6] = '{56, 0, 255, 45, 1, 0};

   initial begin
      int x0;
      model_clear();
      #12;
      check_val("rst_out_valid", int'(out_valid), 0);
      check_val("rst_out_data", int'(out_data), 0);
      #11 reset_L = 1'b1;
      @(posedge clock);
      #1;
      check_val("rst_in_ready", int'(in_ready), 1);

      // constant 100: first result one cycle after the 8th accept, then every 2nd
      out_ready = 1'b1;
      send_n(7, 100);
      check_val("c100_no_early", int'(out_valid), 0);
      send(100);
      check_val("c100_valid", int'(out_valid), 1);
      check_val("c100_data", int'(out_data), 100);
      send(100);
      check_val("c100_k8_idle", int'(out_valid), 0);
      send(100);
      check_val("c100_k9_valid", int'(out_valid), 1);
      check_val("c100_k9_data", int'(out_data), 100);

      // constant 255: full-scale without clamp
      do_flush();
      send_n(8, 255);
      check_val("c255_data", int'(out_data), 255);
      send_n(4, 255);

      // hand-computed vectors, sample k=0 first
      for (int v = 0; v < 6; v++) begin
         do_flush();
         for (int k = 0; k < 8; k++) send(vec[v][k]);
         check_val($sformatf("vec%0d_valid", v), int'(out_valid), 1);
         check_val($sformatf("vec%0d_data", v), int'(out_data), vexp[v]);
      end

      // ramp with downstream stalled after the first result
      do_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(i);
      check_val("stall_valid", int'(out_valid), 1);
      check_val("stall_data", int'(out_data), 4);
      in_data  = 8'd8;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check_val("stall_in_ready", int'(in_ready), 0);
         check_val("stall_hold_data", int'(out_data), 4);
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      for (int i = 8; i < 16; i++) send(i);
      @(posedge clock);
      #1;
      check_val("stall_none_lost", exp_q.size(), 0);
      check_val("stall_idle", int'(out_valid), 0);

      // continuous stream: exactly five results for sixteen fresh samples
      do_flush();
      x0 = n_xfer;
      for (int i = 0; i < 16; i++) send((i * 53 + 7) % 256);
      @(posedge clock);
      #1;
      check_val("stream_count", n_xfer - x0, 5);

      // flush discards a pending result
      out_ready = 1'b0;
      do_flush();
      send_n(8, 50);
      check_val("pend_valid", int'(out_valid), 1);
      do_flush();
      check_val("flush_pend_valid", int'(out_valid), 0);
      check_val("flush_pend_data", int'(out_data), 0);
      check_val("flush_in_ready", int'(in_ready), 1);

      // flush after 5 accepts: next result needs 8 fresh samples
      out_ready = 1'b1;
      send_n(5, 200);
      do_flush();
      send_n(7, 50);
      check_val("flush5_no_early", int'(out_valid), 0);
      send(50);
      check_val("flush5_valid", int'(out_valid), 1);
      check_val("flush5_data", int'(out_data), 50);

      // asynchronous reset with a pending result
      out_ready = 1'b0;
      do_flush();
      send_n(8, 120);
      #2 reset_L = 1'b0;
      #1;
      check_val("areset_valid", int'(out_valid), 0);
      check_val("areset_data", int'(out_data), 0);
      #10 reset_L = 1'b1;
      out_ready = 1'b1;

      // reset pulse after 5 accepts
      send_n(5, 200);
      #2 reset_L = 1'b0;
      #10 reset_L = 1'b1;
      send_n(7, 30);
      check_val("rst5_no_early", int'(out_valid), 0);
      send(30);
      check_val("rst5_valid", int'(out_valid), 1);
      check_val("rst5_data", int'(out_data), 30);
      @(posedge clock);
      #1;
      check_val("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
